// File: rtl/l2_arb_pkg.sv
// Shared definitions for the two-port L2 arbiter: FSM state encoding and
// the port identifiers used for grant and response routing.
package l2_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE_A = 3'd1,
      ISSUE_B = 3'd2,
      WAIT    = 3'd3,
      RESP    = 3'd4
   } arb_state_t;

   // Port 0 is the L1 instruction cache, port 1 the L1 data cache.
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin grant. Purely combinational; the "last granted"
// pointer lives in the parent so it only moves on an actual transfer.
module rr_arbiter2
   import l2_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   // Sole requester wins; on a tie the port that was not granted last wins.
   always_comb begin
      gnt_valid = |req;
      gnt_idx   = PORT_I;
      if (req == 2'b11) begin
         gnt_idx = ~rr_last;
      end else if (req[1]) begin
         gnt_idx = PORT_D;
      end
   end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L1-side port of the L2 cache between the L1 I-cache
// (port 0) and L1 D-cache (port 1). One block request is in flight at a
// time: it is latched, strobed to L2 for two cycles, waited on with a
// timeout, and the registered response is returned to the granted port.
module l2_port_arbiter
   import l2_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int BLOCK_SIZE     = 32,
   parameter int ADDR_WIDTH     = 11,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             p0_req_valid,
   output logic                             p0_req_ready,
   input  logic                             p0_req_write,
   input  logic [ADDR_WIDTH-1:0]            p0_req_addr,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_req_wdata,
   output logic                             p0_rsp_valid,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_rsp_rdata,
   output logic                             p0_rsp_hit,
   output logic                             p0_rsp_err,
   input  logic                             p1_req_valid,
   output logic                             p1_req_ready,
   input  logic                             p1_req_write,
   input  logic [ADDR_WIDTH-1:0]            p1_req_addr,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_req_wdata,
   output logic                             p1_rsp_valid,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_rsp_rdata,
   output logic                             p1_rsp_hit,
   output logic                             p1_rsp_err,
   output logic [ADDR_WIDTH-1:0]            l2_addr,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_wdata,
   output logic                             l2_read,
   output logic                             l2_write,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_rdata,
   input  logic                             l2_ready,
   input  logic                             l2_hit
);

   localparam int BW = BLOCK_SIZE * DATA_WIDTH;
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   arb_state_t            state_reg, state_next;
   logic                  rr_last_reg;
   logic                  port_reg;
   logic                  write_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [BW-1:0]         wdata_reg;
   logic [CW-1:0]         cnt_reg;
   logic [BW-1:0]         rdata_reg;
   logic                  hit_reg;
   logic                  err_reg;

   logic gnt_valid;
   logic gnt_idx;
   logic accept;
   logic capture;
   logic timeout;
   logic issuing;
   logic driving;
   logic resp;

   rr_arbiter2 u_rr (
      .req       ({p1_req_valid, p0_req_valid}),
      .rr_last   (rr_last_reg),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Accept only in IDLE, and never while reset is held so a requester
   // cannot believe it transferred into a register that is being cleared.
   assign accept  = (state_reg == IDLE) && gnt_valid && !rst;
   assign capture = ((state_reg == ISSUE_B) || (state_reg == WAIT)) && l2_ready;
   assign timeout = (state_reg == WAIT) && !l2_ready && (cnt_reg == CNT_LAST);

   // Next-state logic for the request sequencer.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = ISSUE_A;
         ISSUE_A: state_next = ISSUE_B;
         ISSUE_B: state_next = l2_ready ? RESP : WAIT;
         WAIT:    if (capture || timeout) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register plus request latch, round-robin pointer and timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         rr_last_reg <= PORT_D;
         port_reg    <= PORT_I;
         write_reg   <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         cnt_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            port_reg    <= gnt_idx;
            rr_last_reg <= gnt_idx;
            write_reg   <= gnt_idx ? p1_req_write : p0_req_write;
            addr_reg    <= gnt_idx ? p1_req_addr  : p0_req_addr;
            wdata_reg   <= gnt_idx ? p1_req_wdata : p0_req_wdata;
            cnt_reg     <= '0;
         end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   // Response register: L2 result on completion, zero block with err on timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg <= '0;
         hit_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else if (capture) begin
         rdata_reg <= l2_rdata;
         hit_reg   <= l2_hit;
         err_reg   <= 1'b0;
      end else if (timeout) begin
         rdata_reg <= '0;
         hit_reg   <= 1'b0;
         err_reg   <= 1'b1;
      end
   end

   // L2 strobes last exactly the two ISSUE cycles; address and data stay
   // valid through WAIT because L2 keeps using index/tag while it fills.
   always_comb begin
      issuing      = (state_reg == ISSUE_A) || (state_reg == ISSUE_B);
      driving      = issuing || (state_reg == WAIT);
      resp         = (state_reg == RESP);
      l2_read      = issuing && !write_reg;
      l2_write     = issuing && write_reg;
      l2_addr      = driving ? addr_reg  : '0;
      l2_wdata     = driving ? wdata_reg : '0;
      p0_req_ready = accept && (gnt_idx == PORT_I);
      p1_req_ready = accept && (gnt_idx == PORT_D);
   end

   // Route the registered response to the latched port only; the other
   // port's response outputs, including data, stay at zero.
   always_comb begin
      p0_rsp_valid = resp && (port_reg == PORT_I);
      p1_rsp_valid = resp && (port_reg == PORT_D);
      p0_rsp_rdata = p0_rsp_valid ? rdata_reg : '0;
      p1_rsp_rdata = p1_rsp_valid ? rdata_reg : '0;
      p0_rsp_hit   = p0_rsp_valid && hit_reg;
      p1_rsp_hit   = p1_rsp_valid && hit_reg;
      p0_rsp_err   = p0_rsp_valid && err_reg;
      p1_rsp_err   = p1_rsp_valid && err_reg;
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with a small behavioural L2 stub:
// hit/write complete in WAIT three cycles after transfer, read misses add
// a fixed memory latency, and the stub can be muted to force a timeout.
module tb_l2_port_arbiter;

   localparam int DW = 32;
   localparam int BS = 4;
   localparam int AW = 11;
   localparam int TO = 8;
   localparam int BW = DW * BS;
   localparam int MISS_EXTRA = 6;

   localparam logic [BW-1:0] BLK_B = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;
   localparam logic [BW-1:0] BLK_W = 128'hFEEDFACE_00C0FFEE_55AA55AA_01234567;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          p0_req_valid = 1'b0, p0_req_write = 1'b0;
   logic [AW-1:0] p0_req_addr  = '0;
   logic [BW-1:0] p0_req_wdata = '0;
   logic          p1_req_valid = 1'b0, p1_req_write = 1'b0;
   logic [AW-1:0] p1_req_addr  = '0;
   logic [BW-1:0] p1_req_wdata = '0;
   logic          p0_req_ready, p1_req_ready;
   logic          p0_rsp_valid, p0_rsp_hit, p0_rsp_err;
   logic          p1_rsp_valid, p1_rsp_hit, p1_rsp_err;
   logic [BW-1:0] p0_rsp_rdata, p1_rsp_rdata;
   logic [AW-1:0] l2_addr;
   logic [BW-1:0] l2_wdata;
   logic          l2_read, l2_write;
   logic [BW-1:0] l2_rdata = '0;
   logic          l2_ready = 1'b0;
   logic          l2_hit   = 1'b0;

   int checks = 0;
   int errors = 0;

   l2_port_arbiter #(
      .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
      .p0_req_write(p0_req_write), .p0_req_addr(p0_req_addr),
      .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
      .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_hit(p0_rsp_hit), .p0_rsp_err(p0_rsp_err),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
      .p1_req_write(p1_req_write), .p1_req_addr(p1_req_addr),
      .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
      .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_hit(p1_rsp_hit), .p1_rsp_err(p1_rsp_err),
      .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
      .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit)
   );

   // ---------------- L2 stub ----------------
   bit            blk_valid [0:2047];
   bit [BW-1:0]   blk_data  [0:2047];
   logic          stub_dead = 1'b0;
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [BW-1:0] pre_data = '0;
   logic          stub_busy = 1'b0;
   int            stub_cnt = 0;
   logic [AW-1:0] stub_addr = '0;
   logic          stub_wr = 1'b0;
   logic          stub_hit = 1'b0;
   logic [BW-1:0] stub_wd = '0;

   function automatic logic [BW-1:0] mem_block(input logic [AW-1:0] a);
      return {32'hDEAD0000 | 32'(a), 32'h11110000 | 32'(a),
              32'h22220000 | 32'(a), 32'h33330000 | 32'(a)};
   endfunction

   always @(posedge clk) begin
      if (pre_en) begin
         blk_valid[pre_addr] <= 1'b1;
         blk_data[pre_addr]  <= pre_data;
      end
      if (rst) begin
         stub_busy <= 1'b0;
         stub_cnt  <= 0;
         l2_ready  <= 1'b0;
         l2_hit    <= 1'b0;
         l2_rdata  <= '0;
      end else begin
         l2_ready <= 1'b0;
         if (!stub_busy) begin
            if ((l2_read || l2_write) && !stub_dead) begin
               stub_busy <= 1'b1;
               stub_addr <= l2_addr;
               stub_wr   <= l2_write;
               stub_wd   <= l2_wdata;
               stub_hit  <= blk_valid[l2_addr];
               stub_cnt  <= (l2_read && !blk_valid[l2_addr]) ? 1 + MISS_EXTRA : 1;
            end
         end else if (stub_cnt == 1) begin
            l2_ready  <= 1'b1;
            l2_hit    <= stub_hit;
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
            if (stub_wr) begin
               blk_valid[stub_addr] <= 1'b1;
               blk_data[stub_addr]  <= stub_wd;
               l2_rdata <= '0;
            end else if (stub_hit) begin
               l2_rdata <= blk_data[stub_addr];
            end else begin
               blk_valid[stub_addr] <= 1'b1;
               blk_data[stub_addr]  <= mem_block(stub_addr);
               l2_rdata <= mem_block(stub_addr);
            end
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [13:0] out_vec();
      return {l2_read, l2_write, |l2_addr, |l2_wdata, p0_req_ready, p1_req_ready,
              p0_rsp_valid, p1_rsp_valid, |p0_rsp_rdata, |p1_rsp_rdata,
              p0_rsp_hit, p1_rsp_hit, p0_rsp_err, p1_rsp_err};
   endfunction

   task automatic drive(input int port, input bit wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] wd);
      if (port == 0) begin
         p0_req_valid = 1'b1; p0_req_write = wr; p0_req_addr = a; p0_req_wdata = wd;
      end else begin
         p1_req_valid = 1'b1; p1_req_write = wr; p1_req_addr = a; p1_req_wdata = wd;
      end
   endtask

   // Called at a negedge with the port's request already driven; returns at
   // the negedge of the response cycle.
   task automatic finish(input string tag, input int port, input bit wr,
                         input logic [AW-1:0] a, input int exp_wait, input int exp_lat,
                         input logic [BW-1:0] exp_rd, input bit exp_hit, input bit exp_err);
      int waited = 0;
      int lat = -1;
      int strobes = 0, wrong = 0, addr_bad = 0, other = 0;
      logic [BW-1:0] rd = '0;
      logic hit = 1'b0, err = 1'b0;
      logic [AW-1:0] addr_at_resp = '0;
      #1;
      while (!(port == 0 ? p0_req_ready : p1_req_ready) && waited < 20) begin
         @(negedge clk); #1;
         waited++;
      end
      check({tag, " grant_wait"}, waited, exp_wait);
      @(posedge clk); #1;
      if (port == 0) p0_req_valid = 1'b0; else p1_req_valid = 1'b0;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(negedge clk);
         other += (port == 0) ? int'(p1_rsp_valid) : int'(p0_rsp_valid);
         if (port == 0 ? p0_rsp_valid : p1_rsp_valid) begin
            lat  = n;
            rd   = (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
            hit  = (port == 0) ? p0_rsp_hit   : p1_rsp_hit;
            err  = (port == 0) ? p0_rsp_err   : p1_rsp_err;
            addr_at_resp = l2_addr;
         end else begin
            strobes  += wr ? int'(l2_write) : int'(l2_read);
            wrong    += wr ? int'(l2_read)  : int'(l2_write);
            addr_bad += (l2_addr !== a) ? 1 : 0;
         end
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " rdata"}, rd, exp_rd);
      check({tag, " hit"}, hit, exp_hit);
      check({tag, " err"}, err, exp_err);
      check({tag, " strobe_cycles"}, strobes, 2);
      check({tag, " wrong_strobe"}, wrong, 0);
      check({tag, " addr_hold"}, addr_bad, 0);
      check({tag, " other_port_rsp"}, other, 0);
      check({tag, " addr_in_resp"}, addr_at_resp, 0);
      $display("xact %s port %0d wr %0d addr %h lat %0d hit %0d err %0d",
               tag, port, wr, a, lat, hit, err);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pulses;
      rst = 1'b1;
      pre_en = 1'b1; pre_addr = 11'h040; pre_data = BLK_B;
      repeat (3) @(negedge clk);
      pre_en = 1'b0;
      rst = 1'b0;
      #1;
      check("reset_outputs", out_vec(), 14'd0);

      @(negedge clk);
      drive(0, 1'b0, 11'h040, '0);
      finish("read_hit", 0, 1'b0, 11'h040, 0, 4, BLK_B, 1'b1, 1'b0);

      @(negedge clk);
      drive(1, 1'b0, 11'h1A0, '0);
      finish("read_miss", 1, 1'b0, 11'h1A0, 0, 4 + MISS_EXTRA,
             mem_block(11'h1A0), 1'b0, 1'b0);

      @(negedge clk);
      drive(1, 1'b1, 11'h080, BLK_W);
      finish("write_miss", 1, 1'b1, 11'h080, 0, 4, '0, 1'b0, 1'b0);

      @(negedge clk);
      drive(0, 1'b0, 11'h080, '0);
      finish("read_after_write", 0, 1'b0, 11'h080, 0, 4, BLK_W, 1'b1, 1'b0);

      // Contention straight after reset: port 0 wins, port 1 follows.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1'b0, 11'h040, '0);
      drive(1, 1'b0, 11'h080, '0);
      #1;
      check("tie1_ready", {p1_req_ready, p0_req_ready}, 2'b01);
      finish("tie1_p0", 0, 1'b0, 11'h040, 0, 4, BLK_B, 1'b1, 1'b0);
      finish("tie1_p1", 1, 1'b0, 11'h080, 1, 4, BLK_W, 1'b1, 1'b0);

      // Port 1 was granted last, so port 0 wins the next tie.
      @(negedge clk);
      drive(0, 1'b0, 11'h1A0, '0);
      drive(1, 1'b0, 11'h040, '0);
      #1;
      check("tie2_ready", {p1_req_ready, p0_req_ready}, 2'b01);
      finish("tie2_p0", 0, 1'b0, 11'h1A0, 0, 4, mem_block(11'h1A0), 1'b1, 1'b0);
      finish("tie2_p1", 1, 1'b0, 11'h040, 1, 4, BLK_B, 1'b1, 1'b0);

      // Silent L2: error response after TO cycles of WAIT.
      stub_dead = 1'b1;
      @(negedge clk);
      drive(0, 1'b0, 11'h300, '0);
      finish("timeout", 0, 1'b0, 11'h300, 0, 2 + TO + 1, '0, 1'b0, 1'b1);
      stub_dead = 1'b0;

      // Reset during WAIT drops the transaction without a response.
      @(negedge clk);
      drive(0, 1'b0, 11'h400, '0);
      #1;
      check("rstwait_ready", p0_req_ready, 1'b1);
      @(posedge clk); #1;
      p0_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstwait_outputs", out_vec(), 14'd0);
      drive(1, 1'b0, 11'h040, '0);
      finish("after_reset", 1, 1'b0, 11'h040, 0, 4, BLK_B, 1'b1, 1'b0);
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         pulses += int'(p0_rsp_valid) + int'(p1_rsp_valid);
      end
      check("rstwait_no_stale_rsp", pulses, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares one L2_cache L1-side port between two L1 requesters: port 0 = L1 instruction cache, port 1 = L1 data cache.
- Accepts one block request at a time using round-robin arbitration.
- Sequences the L2 strobe/hold protocol, waits for l2_ready with a timeout, and routes the registered response back to the granted port.
- Sits between the two L1 caches and the L2 cache.

Parameters:
- DATA_WIDTH, 32, word width.
- BLOCK_SIZE, 32, words per block; block bus width BW = BLOCK_SIZE*DATA_WIDTH, flat vector.
- ADDR_WIDTH, 11, block address width.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before an error response.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pN_req_valid  in  1  request from port N (N=0,1)
- pN_req_ready  out  1  combinational accept; transfer when valid&&ready
- pN_req_write  in  1  1=write, 0=read
- pN_req_addr  in  ADDR_WIDTH  block address
- pN_req_wdata  in  BW  write block
- pN_rsp_valid  out  1  one-cycle response pulse
- pN_rsp_rdata  out  BW  returned block
- pN_rsp_hit  out  1  L2 hit flag
- pN_rsp_err  out  1  timeout flag
- l2_addr  out  ADDR_WIDTH  to L2 l1_cache_addr
- l2_wdata  out  BW  to L2 l1_cache_data_in
- l2_read  out  1  read strobe
- l2_write  out  1  write strobe
- l2_rdata  in  BW  L2 l1_block_data_out
- l2_ready  in  1  L2 completion pulse
- l2_hit  in  1  L2 hit flag

Behaviour:
- Reset (rst high at a clk edge):
  - State returns to IDLE and rr_last resets to 1, so port 0 wins the first tie.
  - All outputs are 0 and the timeout counter clears.
  - An in-flight transaction is dropped with no response; the requester reissues.
- States: IDLE, ISSUE_A, ISSUE_B, WAIT, RESP.
- IDLE:
  - pN_req_ready = 1 only for the port granted this cycle. Grant goes to the sole valid port; if both are valid, the port != rr_last wins.
  - On transfer: latch port id, write, addr and wdata; set rr_last to the granted port; go to ISSUE_A.
  - pN_req_ready is 0 in every other state.
- ISSUE_A, ISSUE_B:
  - l2_read = !write and l2_write = write, asserted for exactly these 2 cycles. L2 samples the strobe in its IDLE and uses it again in TAG_CHECK.
  - l2_addr and l2_wdata are driven from the latch.
- WAIT:
  - Strobes are 0; l2_addr and l2_wdata are held, because L2 uses the index/tag while filling.
  - Counter increments each cycle.
  - l2_ready sampled high: capture l2_rdata and l2_hit, set err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES without l2_ready: set rdata=0, hit=0, err=1, go to RESP.
- l2_ready during ISSUE_B: treated identically to WAIT (capture, go to RESP).
- l2_ready in IDLE, ISSUE_A or RESP: ignored.
- RESP (1 cycle):
  - rsp_valid, rdata, hit and err are driven to the latched port only; the other port's rsp outputs stay 0.
  - L2 address/data outputs go to 0; next state is IDLE.
  - pN_rsp_rdata is 0 whenever pN_rsp_valid is 0.
- Latency with the real L2: L2 ready appears in WAIT 3 cycles after transfer, giving a hit read or write rsp_valid 4 cycles after transfer. A read miss adds the memory latency.
- Back-to-back: a request pending at RESP is accepted in the next IDLE cycle. Minimum spacing between transfers is 5 cycles.
- Protocol requirements on requesters:
  - A port issues no new request before its own rsp.
  - Request fields must be stable while valid && !ready.
- Counter width is $clog2(TIMEOUT_CYCLES)+1; it clears on entry to ISSUE_A.

Decomposition:
- Shared package l2_arb_pkg holds:
  - state encoding enum (IDLE=0, ISSUE_A=1, ISSUE_B=2, WAIT=3, RESP=4, 3 bits)
  - PORT_I=0, PORT_D=1 constants
- One natural sub-module, rr_arbiter2: a 2-request round-robin grant with rr_last input and a grant-index output. It is combinational, with the pointer register kept in the parent.

Test Plan:
- Read hit: preload L2 addr 0x040 with block B, then p0 read 0x040 -> l2_read high exactly 2 cycles; p0_rsp_valid 4 cycles after transfer with rdata=B, hit=1, err=0; p1 rsp outputs stay 0.
- Read miss: p1 read 0x1A0 with memory stub asserting mem_ready 5 cycles after mem_read -> p1_rsp_valid with the memory block, hit=0. l2_addr holds 0x1A0 throughout WAIT.
- Write: p1 write 0x080 with data W -> l2_write 2 cycles, rsp hit=0 (miss allocate); a following p0 read 0x080 -> rdata=W, hit=1.
- Contention: both valid in the same cycle after reset -> p0 granted first, p1 accepted in the first IDLE after p0's RESP. Both valid again -> p0 granted (rr_last=1).
- Timeout: L2 stub never asserts ready, TIMEOUT_CYCLES=8 -> rsp_valid 8 WAIT cycles later with err=1, rdata=0, hit=0.
- Reset mid-WAIT: rst high 1 cycle -> next cycle all outputs 0, state IDLE, no rsp pulse; a fresh p1 request is accepted immediately.
